// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the three-master CPU bus arbiter.
// States, master indices, and the modulo-3 helper used by round-robin selection.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int NUM_MASTERS = 3;

  localparam logic [1:0] M_IFETCH = 2'd0;
  localparam logic [1:0] M_DATA   = 2'd1;
  localparam logic [1:0] M_DMA    = 2'd2;

  // Folds a value in 0..5 back onto a master index in 0..2.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

endpackage

// File: rtl/bus_rr_picker.sv
// Round-robin winner select: priority runs rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
// Purely combinational, zero latency, no backpressure.
module bus_rr_picker
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             rr_ptr,
  output logic                   valid,
  output logic [1:0]             winner
);

  logic [1:0] idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    valid  = 1'b0;
    winner = M_IFETCH;
    idx    = M_IFETCH;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = wrap3({1'b0, rr_ptr} + 3'(k));
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for one outstanding CPU bus transaction; grant -> bus_request in 1 cycle.
// Responses are steered combinationally; a watchdog turns a silent slave into an error.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]    m_write,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  input  logic [4*NUM_MASTERS-1:0]  m_wmask,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [NUM_MASTERS-1:0]    m_error,
  output logic [31:0]               m_rdata,
  output logic                      bus_request,
  output logic [31:0]               bus_address,
  output logic                      bus_write,
  output logic [31:0]               bus_wdata,
  output logic [3:0]                bus_wmask,
  input  logic [31:0]               bus_rdata,
  input  logic                      bus_ack,
  input  logic                      bus_error
);

  localparam logic [TIMEOUT_W-1:0] WDOG_LIMIT = TIMEOUT_W'(TIMEOUT);

  state_t               state;
  logic [1:0]           grant;
  logic [1:0]           rr_ptr;
  logic [TIMEOUT_W-1:0] wdog;

  logic                 pick_vld;
  logic [1:0]           pick_winner;
  logic                 busy;
  logic                 timed_out;

  logic [31:0] addr_arr  [NUM_MASTERS];
  logic [31:0] wdata_arr [NUM_MASTERS];
  logic [3:0]  wmask_arr [NUM_MASTERS];

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      addr_arr[i]  = m_addr[32*i +: 32];
      wdata_arr[i] = m_wdata[32*i +: 32];
      wmask_arr[i] = m_wmask[4*i +: 4];
    end
  end

  bus_rr_picker u_picker (
    .req    (m_req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .winner (pick_winner)
  );

  assign busy      = (state == ISSUE) || (state == WAIT);
  assign timed_out = (state == WAIT) && (wdog == WDOG_LIMIT);

  // Ack beats error; a late ack while IDLE never reaches a master.
  always_comb begin
    m_ack   = '0;
    m_error = '0;
    m_rdata = '0;
    if (busy) begin
      if (bus_ack) begin
        m_ack[grant] = 1'b1;
        m_rdata      = bus_rdata;
      end else if (bus_error || timed_out) begin
        m_error[grant] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= M_IFETCH;
      rr_ptr      <= M_DMA;
      wdog        <= '0;
      bus_request <= 1'b0;
      bus_address <= '0;
      bus_write   <= 1'b0;
      bus_wdata   <= '0;
      bus_wmask   <= '0;
    end else begin
      bus_request <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant       <= pick_winner;
            rr_ptr      <= pick_winner;
            bus_address <= addr_arr[pick_winner];
            bus_write   <= m_write[pick_winner];
            bus_wdata   <= wdata_arr[pick_winner];
            bus_wmask   <= wmask_arr[pick_winner];
            bus_request <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus_ack || bus_error) begin
            state <= IDLE;
          end else begin
            wdog  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus_ack || bus_error || timed_out) begin
            state <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a transaction-level reference model checked every cycle.
module tb_bus_arbiter;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  m_req;
  logic [95:0] m_addr;
  logic [2:0]  m_write;
  logic [95:0] m_wdata;
  logic [11:0] m_wmask;
  logic [2:0]  m_ack;
  logic [2:0]  m_error;
  logic [31:0] m_rdata;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_error;

  int checks = 0;
  int failures = 0;

  bus_arbiter #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .m_req       (m_req),
    .m_addr      (m_addr),
    .m_write     (m_write),
    .m_wdata     (m_wdata),
    .m_wmask     (m_wmask),
    .m_ack       (m_ack),
    .m_error     (m_error),
    .m_rdata     (m_rdata),
    .bus_request (bus_request),
    .bus_address (bus_address),
    .bus_write   (bus_write),
    .bus_wdata   (bus_wdata),
    .bus_wmask   (bus_wmask),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .bus_error   (bus_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is "age" cycles old since its issue cycle.
  bit          mbusy = 1'b0;
  int          mgrant = 0;
  int          mage = 0;
  int          mlast = 2;
  logic [31:0] maddr, mwdata;
  logic        mwrite;
  logic [3:0]  mwmask;
  int          cyc_n = 0;
  int          glog_m[$];
  int          glog_c[$];

  always @(negedge clock) begin
    logic [2:0] exp_ack, exp_err;
    bit done, found;
    int win, c;
    cyc_n++;
    if (reset) begin
      chk("rst_m_ack", m_ack, 0);
      chk("rst_m_error", m_error, 0);
      chk("rst_m_rdata", m_rdata, 0);
      chk("rst_bus_request", bus_request, 0);
      chk("rst_bus_address", bus_address, 0);
      chk("rst_bus_write", bus_write, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_bus_wmask", bus_wmask, 0);
      mbusy = 1'b0;
      mlast = 2;
    end else begin
      exp_ack = '0;
      exp_err = '0;
      done = 1'b0;
      if (mbusy) begin
        if (bus_ack) begin
          exp_ack[mgrant] = 1'b1;
          done = 1'b1;
        end else if (bus_error || mage == TO + 1) begin
          exp_err[mgrant] = 1'b1;
          done = 1'b1;
        end
        chk("bus_request", bus_request, mage == 0);
        chk("bus_address", bus_address, maddr);
        chk("bus_write", bus_write, mwrite);
        chk("bus_wdata", bus_wdata, mwdata);
        chk("bus_wmask", bus_wmask, mwmask);
      end else begin
        chk("bus_request_idle", bus_request, 0);
      end
      chk("m_ack", m_ack, exp_ack);
      chk("m_error", m_error, exp_err);
      if (exp_ack != 0) chk("m_rdata", m_rdata, bus_rdata);

      if (mbusy) begin
        if (done) mbusy = 1'b0;
        else mage++;
      end else if (m_req != 0) begin
        found = 1'b0;
        win = 0;
        for (int k = 1; k <= 3; k++) begin
          c = (mlast + k) % 3;
          if (!found && m_req[c]) begin
            found = 1'b1;
            win = c;
          end
        end
        mbusy  = 1'b1;
        mage   = 0;
        mgrant = win;
        mlast  = win;
        maddr  = m_addr[32*win +: 32];
        mwrite = m_write[win];
        mwdata = m_wdata[32*win +: 32];
        mwmask = m_wmask[4*win +: 4];
        glog_m.push_back(win);
        glog_c.push_back(cyc_n);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [2:0] ackd;

  initial begin
    reset     = 1'b1;
    m_req     = '0;
    m_addr    = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    m_write   = 3'b000;
    m_wdata   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    m_wmask   = 12'hFFF;
    bus_rdata = '0;
    bus_ack   = 1'b0;
    bus_error = 1'b0;
    repeat (2) tick();
    chk("reset_bus_request", bus_request, 0);
    chk("reset_m_ack", m_ack, 0);
    reset = 1'b0;

    // Round-robin: all masters request, slave acks in ISSUE.
    glog_m.delete();
    glog_c.delete();
    m_req = 3'b111;
    ackd  = '0;
    repeat (11) begin
      tick();
      m_req     = 3'b111 & ~ackd;
      bus_ack   = bus_request;
      bus_rdata = $urandom;
      #1;
      ackd = m_ack;
    end
    tick();
    m_req   = '0;
    bus_ack = 1'b0;
    tick();
    chk("rr_count", glog_m.size(), 6);
    for (int i = 0; i < glog_m.size() && i < 6; i++) begin
      chk("rr_order", glog_m[i], i % 3);
      if (i > 0) chk("rr_spacing", glog_c[i] - glog_c[i-1], 2);
    end

    // Single read from the data master.
    m_req = 3'b010;
    m_addr[63:32] = 32'h0000_0100;
    tick();
    chk("rd_bus_request", bus_request, 1);
    chk("rd_bus_address", bus_address, 32'h0000_0100);
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_m_ack", m_ack, 3'b010);
    chk("rd_m_rdata", m_rdata, 32'hDEAD_BEEF);
    tick();
    m_req   = '0;
    bus_ack = 1'b0;
    chk("rd_idle_request", bus_request, 0);
    chk("rd_idle_ack", m_ack, 0);

    // Decode error from the DMA master.
    m_req = 3'b100;
    m_addr[95:64] = 32'h8000_0000;
    tick();
    chk("de_bus_address", bus_address, 32'h8000_0000);
    bus_error = 1'b1;
    #1;
    chk("de_m_error", m_error, 3'b100);
    chk("de_m_ack", m_ack, 3'b000);
    tick();
    m_req     = '0;
    bus_error = 1'b0;
    chk("de_idle_request", bus_request, 0);

    // Watchdog timeout on an instruction-fetch write, then a late ack.
    m_req    = 3'b001;
    m_write  = 3'b001;
    m_addr[31:0]  = 32'h0000_0200;
    m_wdata[31:0] = 32'h1234_5678;
    m_wmask[3:0]  = 4'h3;
    tick();
    chk("to_bus_wdata", bus_wdata, 32'h1234_5678);
    chk("to_bus_wmask", bus_wmask, 4'h3);
    for (int w = 1; w <= 5; w++) begin
      tick();
      chk("to_wait_error", m_error, (w == 5) ? 3'b001 : 3'b000);
    end
    tick();
    m_req   = '0;
    m_write = '0;
    tick();
    bus_ack = 1'b1;
    #1;
    chk("to_late_ack", m_ack, 3'b000);
    tick();
    bus_ack = 1'b0;

    // Ack and error together in WAIT: ack wins.
    m_req = 3'b010;
    tick();
    tick();
    tick();
    bus_ack   = 1'b1;
    bus_error = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    #1;
    chk("ae_m_ack", m_ack, 3'b010);
    chk("ae_m_error", m_error, 3'b000);
    chk("ae_m_rdata", m_rdata, 32'hCAFE_F00D);
    tick();
    m_req     = '0;
    bus_ack   = 1'b0;
    bus_error = 1'b0;

    // Reset while in WAIT, then the next grant goes to master 0.
    m_req = 3'b100;
    m_addr[31:0] = 32'h0000_1000;
    tick();
    tick();
    tick();
    reset   = 1'b1;
    bus_ack = 1'b1;
    #1;
    chk("mr_m_ack", m_ack, 0);
    chk("mr_m_error", m_error, 0);
    chk("mr_bus_request", bus_request, 0);
    chk("mr_bus_address", bus_address, 0);
    tick();
    reset   = 1'b0;
    bus_ack = 1'b0;
    m_req   = 3'b111;
    tick();
    chk("mr_next_address", bus_address, 32'h0000_1000);
    bus_ack = 1'b1;
    #1;
    chk("mr_next_ack", m_ack, 3'b001);
    tick();
    m_req   = '0;
    bus_ack = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
